// File: rtl/register_skid_pipeline.sv
// rtl/register_skid_pipeline.sv - cascaded 2-entry skid stages with enable, flush and occupancy
module register_skid_pipeline #(
    parameter int WORD_LENGTH = 8,
    parameter int STAGES      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [WORD_LENGTH-1:0]           in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WORD_LENGTH-1:0]           out_data,
    input  logic                             out_ready,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Link k feeds stage k; link STAGES is the block output.
    logic [STAGES:0]                  link_valid;
    logic [STAGES:0]                  link_ready;
    logic [STAGES:0][WORD_LENGTH-1:0] link_data;

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = in_data;
    assign link_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_state_t           state, state_nx;
        logic [WORD_LENGTH-1:0] main_q, main_nx;
        logic [WORD_LENGTH-1:0] skid_q, skid_nx;
        logic                   ready_q;
        logic                   accept;
        logic                   taken;

        assign accept = link_valid[k] & ready_q & enable;
        assign taken  = (state != ST_EMPTY) & link_ready[k+1] & enable;

        always_comb begin
            state_nx = state;
            main_nx  = main_q;
            skid_nx  = skid_q;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nx = ST_BUSY;
                        main_nx  = link_data[k];
                    end
                end
                ST_BUSY: begin
                    if (accept && !taken) begin
                        state_nx = ST_FULL;
                        skid_nx  = link_data[k];
                    end else if (!accept && taken) begin
                        state_nx = ST_EMPTY;
                    end else if (accept && taken) begin
                        main_nx  = link_data[k];
                    end
                end
                ST_FULL: begin
                    if (taken) begin
                        state_nx = ST_BUSY;
                        main_nx  = skid_q;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
            // Flush empties the stage but leaves stale data in place.
            if (clear) begin
                state_nx = ST_EMPTY;
                main_nx  = main_q;
                skid_nx  = skid_q;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= ST_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                state   <= state_nx;
                main_q  <= main_nx;
                skid_q  <= skid_nx;
                ready_q <= (state_nx != ST_FULL);
            end
        end

        assign link_ready[k]   = ready_q;
        assign link_valid[k+1] = (state != ST_EMPTY);
        assign link_data[k+1]  = main_q;
    end

    assign in_ready  = link_ready[0] & enable;
    assign out_valid = link_valid[STAGES] & enable;
    assign out_data  = link_data[STAGES];

    logic             in_acc;
    logic             out_acc;
    logic [OCC_W-1:0] occ_q;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else if (clear) begin
            occ_q <= '0;
        end else if (in_acc && !out_acc) begin
            occ_q <= occ_q + 1'b1;
        end else if (!in_acc && out_acc) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_register_skid_pipeline.sv
// tb/tb_register_skid_pipeline.sv - randomized scoreboard bench for register_skid_pipeline
module tb_register_skid_pipeline;

    localparam int WL  = 8;
    localparam int ST  = 2;
    localparam int CAP = 2*ST;
    localparam int OW  = $clog2(2*ST+1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [WL-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [WL-1:0] out_data;
    logic [OW-1:0] occupancy;

    int checks = 0;
    int failures = 0;

    logic [WL-1:0] exp_q[$];
    logic [WL-1:0] exp_w;
    logic          ob_ir;
    logic          ob_ov;
    logic [WL-1:0] ob_od;
    int            ob_occ;

    always #5 clk = ~clk;

    register_skid_pipeline #(.WORD_LENGTH(WL), .STAGES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    task automatic observe();
        #1;
        ob_ir  = in_ready;
        ob_ov  = out_valid;
        ob_od  = out_data;
        ob_occ = int'(occupancy);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable = 1'b1;
        observe();
        checks++; if (ob_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", ob_ov); end
        checks++; if (ob_od !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h required=00", ob_od); end
        checks++; if (ob_occ != 0) begin failures++; $display("FAIL reset_occupancy got=%0d required=0", ob_occ); end
        checks++; if (ob_ir !== 1'b1) begin failures++; $display("FAIL reset_in_ready_en1 got=%b required=1", ob_ir); end
        enable = 1'b0;
        observe();
        checks++; if (ob_ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready_en0 got=%b required=0", ob_ir); end
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_stream();
        int first_acc = -1;
        int first_out = -1;
        int last_out = -1;
        int n_out = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c < 16);
            in_data  = WL'(c + 1);
            observe();
            if (c < 16) begin
                checks++; if (ob_ir !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle=%0d got=%b required=1", c, ob_ir); end
            end
            if (ob_ov) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
                exp_w = 'x;
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL stream_data got=%h required=%h", ob_od, exp_w); end
            end
            if (in_valid && ob_ir) begin
                if (first_acc < 0) first_acc = c;
                exp_q.push_back(in_data);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++; if (first_out - first_acc != ST) begin failures++; $display("FAIL stream_latency got=%0d required=%0d", first_out - first_acc, ST); end
        checks++; if (n_out != 16 || last_out - first_out != 15) begin failures++; $display("FAIL stream_throughput got_words=%0d got_span=%0d required=16/15", n_out, last_out - first_out); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_drain got_left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_out = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = WL'(8'hA0 + n_acc);
            observe();
            if (ob_ir) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        observe();
        checks++; if (n_acc != CAP) begin failures++; $display("FAIL bp_accepted got=%0d required=%0d", n_acc, CAP); end
        checks++; if (ob_ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b required=0", ob_ir); end
        checks++; if (ob_occ != CAP) begin failures++; $display("FAIL bp_occupancy got=%0d required=%0d", ob_occ, CAP); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            observe();
            if (ob_ov) begin
                exp_w = WL'(8'hA0 + n_out);
                n_out++;
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL bp_order got=%h required=%h", ob_od, exp_w); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            next_cycle();
        end
        checks++; if (n_out != CAP) begin failures++; $display("FAIL bp_drained got=%0d required=%0d", n_out, CAP); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = WL'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            observe();
            checks++; if (ob_occ != exp_q.size()) begin failures++; $display("FAIL rand_occupancy cycle=%0d got=%0d required=%0d", c, ob_occ, exp_q.size()); end
            if (exp_q.size() == CAP) begin
                checks++; if (ob_ir !== 1'b0) begin failures++; $display("FAIL rand_full_ready cycle=%0d got=%b required=0", c, ob_ir); end
            end
            if (ob_ov && out_ready) begin
                exp_w = 'x;
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL rand_data cycle=%0d got=%h required=%h", c, ob_od, exp_w); end
            end
            if (in_valid && ob_ir) exp_q.push_back(in_data);
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            observe();
            if (ob_ov) begin
                exp_w = 'x;
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL rand_drain_data got=%h required=%h", ob_od, exp_w); end
            end
            next_cycle();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_loss got_left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_clear();
        int n_acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10 && n_acc < 3; c++) begin
            in_data = WL'(8'h11 + n_acc);
            observe();
            if (ob_ir) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            next_cycle();
        end
        in_data = 8'h55;
        clear   = 1'b1;
        observe();
        checks++; if (ob_occ != 3) begin failures++; $display("FAIL clear_setup_occupancy got=%0d required=3", ob_occ); end
        next_cycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        observe();
        checks++; if (ob_occ != 0) begin failures++; $display("FAIL clear_occupancy got=%0d required=0", ob_occ); end
        checks++; if (ob_ov !== 1'b0) begin failures++; $display("FAIL clear_out_valid got=%b required=0", ob_ov); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            observe();
            checks++; if (ob_ov !== 1'b0) begin failures++; $display("FAIL clear_dropped_word got_valid=%b got_data=%h required=0", ob_ov, ob_od); end
            next_cycle();
        end
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            in_data  = WL'(8'h21 + c);
            observe();
            if (ob_ov) begin
                exp_w = 'x;
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL clear_after_data got=%h required=%h", ob_od, exp_w); end
            end
            if (in_valid && ob_ir) exp_q.push_back(in_data);
            next_cycle();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL clear_after_loss got_left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_enable();
        int idx = 0;
        int frz = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            enable   = !(c >= 8 && c < 13);
            in_valid = (idx < 20);
            in_data  = WL'(8'h30 + idx);
            observe();
            if (c == 8) frz = exp_q.size();
            if (!enable) begin
                checks++; if (ob_ir !== 1'b0 || ob_ov !== 1'b0) begin failures++; $display("FAIL en_gate cycle=%0d got_ir=%b got_ov=%b required=0/0", c, ob_ir, ob_ov); end
                checks++; if (ob_occ != frz) begin failures++; $display("FAIL en_frozen_occ cycle=%0d got=%0d required=%0d", c, ob_occ, frz); end
            end
            if (c == 13) begin
                checks++; if (ob_ov !== 1'b1 || ob_ir !== 1'b1) begin failures++; $display("FAIL en_resume got_ov=%b got_ir=%b required=1/1", ob_ov, ob_ir); end
            end
            if (ob_ov) begin
                exp_w = 'x;
                if (exp_q.size() != 0) exp_w = exp_q.pop_front();
                checks++; if (ob_od !== exp_w) begin failures++; $display("FAIL en_data got=%h required=%h", ob_od, exp_w); end
            end
            if (in_valid && ob_ir) begin
                exp_q.push_back(in_data);
                idx++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        checks++; if (idx != 20 || exp_q.size() != 0) begin failures++; $display("FAIL en_loss got_sent=%0d got_left=%0d required=20/0", idx, exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int n_acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10 && n_acc < 2; c++) begin
            in_data = WL'(8'h3C + n_acc);
            observe();
            if (ob_ir) n_acc++;
            next_cycle();
        end
        in_valid = 1'b0;
        observe();
        checks++; if (ob_occ != 2) begin failures++; $display("FAIL arst_setup_occupancy got=%0d required=2", ob_occ); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b required=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL arst_out_data got=%h required=00", out_data); end
        checks++; if (occupancy != 0) begin failures++; $display("FAIL arst_occupancy got=%0d required=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b required=1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_clear();
        test_enable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
